// File: rtl/fetch_buffer.sv
// fetch_buffer: compacting dual-issue instruction queue between fetch2 and decode.
// Up to two entries in and two entries out per cycle. A flush or reset empties the
// queue in one cycle. All outputs are driven from registered state only.
module fetch_buffer #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic [31:0]   inst0_i,
    input  logic [31:0]   inst1_i,
    input  logic          valid0_i,
    input  logic          valid1_i,
    input  logic          pred_1_i,
    input  logic [31:0]   pc_i,
    input  logic          branch_flush_i,
    input  logic [1:0]    deq_count_i,
    output logic          ready_o,
    output logic [31:0]   inst0_o,
    output logic [31:0]   inst1_o,
    output logic [31:0]   pc0_o,
    output logic [31:0]   pc1_o,
    output logic          pred0_o,
    output logic          pred1_o,
    output logic          valid0_o,
    output logic          valid1_o,
    output logic [CW-1:0] occupancy_o
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   r_inst [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic          r_pred [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_ready;
    logic          w_enq;
    logic [1:0]    w_enq_n;
    logic [CW-1:0] w_enq_add;
    logic [1:0]    w_deq_req;
    logic [CW-1:0] w_deq_eff;
    logic [31:0]   w_pc_plus4;
    logic [PW-1:0] w_tail1;
    logic [PW-1:0] w_head1;
    logic [31:0]   w_wa_inst;
    logic [31:0]   w_wa_pc;
    logic          w_wa_pred;

    // Two free slots are always reserved, so an accepted pair can never overflow.
    assign w_ready    = (r_count <= CW'(DEPTH - 2));
    assign w_enq      = w_ready & ~branch_flush_i & ~reset_i;
    assign w_enq_n    = {1'b0, valid0_i} + {1'b0, valid1_i};
    assign w_enq_add  = w_enq ? CW'(w_enq_n) : '0;
    assign w_pc_plus4 = pc_i + 32'd4;
    assign w_tail1    = r_tail + PW'(1);
    assign w_head1    = r_head + PW'(1);

    // Clamp the dequeue request to 2 and to current occupancy; pick the entry for the tail slot.
    always_comb begin
        w_deq_req = (deq_count_i == 2'd3) ? 2'd2 : deq_count_i;
        w_deq_eff = (CW'(w_deq_req) > r_count) ? r_count : CW'(w_deq_req);
        if (valid0_i) begin
            w_wa_inst = inst0_i;
            w_wa_pc   = pc_i;
            w_wa_pred = 1'b0;
        end else begin
            w_wa_inst = inst1_i;
            w_wa_pc   = w_pc_plus4;
            w_wa_pred = pred_1_i;
        end
    end

    // Storage write: a lone valid slot compacts to tail; a full pair fills tail and tail+1.
    always_ff @(posedge clock_i) begin
        if (w_enq && (valid0_i || valid1_i)) begin
            r_inst[r_tail] <= w_wa_inst;
            r_pc[r_tail]   <= w_wa_pc;
            r_pred[r_tail] <= w_wa_pred;
            if (valid0_i && valid1_i) begin
                r_inst[w_tail1] <= inst1_i;
                r_pc[w_tail1]   <= w_pc_plus4;
                r_pred[w_tail1] <= pred_1_i;
            end
        end
    end

    // Pointer and occupancy update; flush and reset drop any same-cycle enqueue/dequeue.
    always_ff @(posedge clock_i) begin
        if (reset_i || branch_flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_deq_eff);
            r_tail  <= r_tail + PW'(w_enq_add);
            r_count <= r_count + w_enq_add - w_deq_eff;
        end
    end

    assign ready_o     = w_ready;
    assign occupancy_o = r_count;
    assign valid0_o    = (r_count != '0);
    assign valid1_o    = (r_count >= CW'(2));
    assign inst0_o     = valid0_o ? r_inst[r_head]  : '0;
    assign pc0_o       = valid0_o ? r_pc[r_head]    : '0;
    assign pred0_o     = valid0_o ? r_pred[r_head]  : 1'b0;
    assign inst1_o     = valid1_o ? r_inst[w_head1] : '0;
    assign pc1_o       = valid1_o ? r_pc[w_head1]   : '0;
    assign pred1_o     = valid1_o ? r_pred[w_head1] : 1'b0;

endmodule
